// File: rtl/zap_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : zap_frame_ctrl
//  Purpose  : Zapper frame sequencer. It turns a trigger pull into one black
//             cheat-check frame followed by one white-box frame per target,
//             drives the video overlay and emits a one-cycle scored result.
//  Revision : 1.0  initial release
// ============================================================================
module zap_frame_ctrl #(
    parameter int NUM_TARGETS = 2,
    parameter int TGT_W       = 2
) (
    input  logic             clk,
    input  logic             rst,            // asynchronous, active-low
    input  logic             shot,
    input  logic             hit,
    input  logic             frame_start,
    output logic             blank_screen,
    output logic             draw_target,
    output logic [TGT_W-1:0] target_idx,
    output logic             busy,
    output logic             result_valid,
    output logic             result_hit,
    output logic             result_cheat,
    output logic [TGT_W-1:0] result_target
);

    localparam logic [TGT_W-1:0] c_LAST_IDX = TGT_W'(NUM_TARGETS - 1);
    localparam logic [TGT_W-1:0] c_IDX_ONE  = TGT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARM    = 3'd1,
        S_BLACK  = 3'd2,
        S_TARGET = 3'd3,
        S_REPORT = 3'd4,
        S_HOLD   = 3'd5
    } state_t;

    state_t           state_q;
    logic             shot_q;
    logic             hit_q;
    logic [TGT_W-1:0] idx_q;
    logic             cheat_q;
    logic             hit_flag_q;
    logic [TGT_W-1:0] tgt_q;

    logic             blank_q;
    logic             draw_q;
    logic [TGT_W-1:0] target_idx_q;
    logic             busy_q;
    logic             result_valid_q;
    logic             result_hit_q;
    logic             result_cheat_q;
    logic [TGT_W-1:0] result_target_q;

    // Rising-edge detection on the already-synchronized zapper levels.
    logic             w_shot_rise;
    logic             w_hit_rise;
    // Hit credit including a rise coincident with the final frame_start,
    // so the result launched on that same edge already reflects it.
    logic             w_credit_now;
    logic             w_hit_final_d;
    logic [TGT_W-1:0] w_tgt_final_d;

    assign w_shot_rise   = shot & ~shot_q;
    assign w_hit_rise    = hit & ~hit_q;
    assign w_credit_now  = w_hit_rise & ~cheat_q & ~hit_flag_q;
    assign w_hit_final_d = (hit_flag_q | w_credit_now) & ~cheat_q;
    assign w_tgt_final_d = hit_flag_q ? tgt_q : (w_credit_now ? idx_q : '0);

    // Frame sequencer: state, scoring flags and registered overlay/result outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= S_IDLE;
            shot_q          <= 1'b0;
            hit_q           <= 1'b0;
            idx_q           <= '0;
            cheat_q         <= 1'b0;
            hit_flag_q      <= 1'b0;
            tgt_q           <= '0;
            blank_q         <= 1'b0;
            draw_q          <= 1'b0;
            target_idx_q    <= '0;
            busy_q          <= 1'b0;
            result_valid_q  <= 1'b0;
            result_hit_q    <= 1'b0;
            result_cheat_q  <= 1'b0;
            result_target_q <= '0;
        end else begin
            shot_q <= shot;
            hit_q  <= hit;

            // Result fields are only non-zero during the single REPORT cycle.
            result_valid_q  <= 1'b0;
            result_hit_q    <= 1'b0;
            result_cheat_q  <= 1'b0;
            result_target_q <= '0;

            case (state_q)
                S_IDLE: begin
                    if (w_shot_rise) begin
                        state_q    <= S_ARM;
                        busy_q     <= 1'b1;
                        idx_q      <= '0;
                        cheat_q    <= 1'b0;
                        hit_flag_q <= 1'b0;
                        tgt_q      <= '0;
                    end
                end

                S_ARM: begin
                    if (frame_start) begin
                        state_q <= S_BLACK;
                        blank_q <= 1'b1;
                    end
                end

                S_BLACK: begin
                    // Light on a black screen means a lamp or glare, not a target.
                    if (w_hit_rise) begin
                        cheat_q <= 1'b1;
                    end
                    if (frame_start) begin
                        state_q      <= S_TARGET;
                        idx_q        <= '0;
                        blank_q      <= 1'b0;
                        draw_q       <= 1'b1;
                        target_idx_q <= '0;
                    end
                end

                S_TARGET: begin
                    // First qualified rise wins; credited before any index advance.
                    if (w_credit_now) begin
                        hit_flag_q <= 1'b1;
                        tgt_q      <= idx_q;
                    end
                    if (frame_start) begin
                        if (idx_q == c_LAST_IDX) begin
                            state_q         <= S_REPORT;
                            draw_q          <= 1'b0;
                            target_idx_q    <= '0;
                            result_valid_q  <= 1'b1;
                            result_hit_q    <= w_hit_final_d;
                            result_cheat_q  <= cheat_q;
                            result_target_q <= w_hit_final_d ? w_tgt_final_d : '0;
                        end else begin
                            idx_q        <= idx_q + c_IDX_ONE;
                            target_idx_q <= idx_q + c_IDX_ONE;
                        end
                    end
                end

                S_REPORT: begin
                    state_q <= S_HOLD;
                end

                S_HOLD: begin
                    // Require trigger release so one held pull cannot re-fire.
                    if (!shot) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    blank_q <= 1'b0;
                    draw_q  <= 1'b0;
                end
            endcase
        end
    end

    assign blank_screen  = blank_q;
    assign draw_target   = draw_q;
    assign target_idx    = target_idx_q;
    assign busy          = busy_q;
    assign result_valid  = result_valid_q;
    assign result_hit    = result_hit_q;
    assign result_cheat  = result_cheat_q;
    assign result_target = result_target_q;

endmodule
`default_nettype wire

// File: tb/tb_zap_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_zap_frame_ctrl
//  Purpose  : Directed self-checking bench for zap_frame_ctrl (NUM_TARGETS=2).
//  Revision : 1.0  initial release
// ============================================================================
module tb_zap_frame_ctrl;

    localparam int FRAME_CYC = 6;

    logic       clk = 1'b0;
    logic       rst;
    logic       shot;
    logic       hit;
    logic       frame_start;
    logic       blank_screen;
    logic       draw_target;
    logic [1:0] target_idx;
    logic       busy;
    logic       result_valid;
    logic       result_hit;
    logic       result_cheat;
    logic [1:0] result_target;

    int         tests_run    = 0;
    int         tests_failed = 0;
    int         blank_cnt;
    int         draw_cnt;
    int         rv_cnt;
    int         stray_cnt = 0;
    logic       cap_hit;
    logic       cap_cheat;
    logic [1:0] cap_tgt;

    zap_frame_ctrl #(
        .NUM_TARGETS (2),
        .TGT_W       (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .shot          (shot),
        .hit           (hit),
        .frame_start   (frame_start),
        .blank_screen  (blank_screen),
        .draw_target   (draw_target),
        .target_idx    (target_idx),
        .busy          (busy),
        .result_valid  (result_valid),
        .result_hit    (result_hit),
        .result_cheat  (result_cheat),
        .result_target (result_target)
    );

    always #5 clk = ~clk;

    // Advance n cycles, sampling at each negedge and accumulating activity.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (blank_screen) blank_cnt++;
            if (draw_target)  draw_cnt++;
            if (result_valid) begin
                rv_cnt++;
                cap_hit   = result_hit;
                cap_cheat = result_cheat;
                cap_tgt   = result_target;
            end else if (result_hit || result_cheat || result_target != 2'd0) begin
                stray_cnt++;
            end
        end
    endtask

    task automatic clear_counts();
        blank_cnt = 0;
        draw_cnt  = 0;
        rv_cnt    = 0;
        cap_hit   = 1'b0;
        cap_cheat = 1'b0;
        cap_tgt   = 2'd0;
    endtask

    // One video frame: a one-cycle frame_start pulse then the frame body.
    task automatic frame();
        frame_start = 1'b1;
        step(1);
        frame_start = 1'b0;
        step(FRAME_CYC - 1);
    endtask

    task automatic pull();
        shot = 1'b1;
        step(1);
        shot = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; shot = 1'b0; hit = 1'b0; frame_start = 1'b0;
        clear_counts();
        step(2);
        tests_run++;
        if ({blank_screen, draw_target, target_idx, busy, result_valid,
             result_hit, result_cheat, result_target} !== 10'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got blank=%b draw=%b idx=%0d busy=%b rv=%b, required all 0",
                     blank_screen, draw_target, target_idx, busy, result_valid);
        end
        rst = 1'b1;
        step(2);
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_after_release: busy=%b, required 0", busy);
        end
    endtask

    // Hit rises mid target frame 1; shot released mid-sequence must not abort.
    task automatic test_hit_target1();
        clear_counts();
        shot = 1'b1;
        step(1);
        tests_run++;
        if (busy !== 1'b1 || blank_screen !== 1'b0) begin
            tests_failed++;
            $display("FAIL arm_state: busy=%b blank=%b, required busy=1 blank=0", busy, blank_screen);
        end
        frame();
        tests_run++;
        if (blank_screen !== 1'b1 || draw_target !== 1'b0) begin
            tests_failed++;
            $display("FAIL black_frame: blank=%b draw=%b, required blank=1 draw=0", blank_screen, draw_target);
        end
        frame();
        shot = 1'b0;
        tests_run++;
        if (blank_screen !== 1'b0 || draw_target !== 1'b1 || target_idx !== 2'd0) begin
            tests_failed++;
            $display("FAIL target0_frame: blank=%b draw=%b idx=%0d, required 0 1 0",
                     blank_screen, draw_target, target_idx);
        end
        frame();
        tests_run++;
        if (draw_target !== 1'b1 || target_idx !== 2'd1) begin
            tests_failed++;
            $display("FAIL target1_frame: draw=%b idx=%0d, required 1 1", draw_target, target_idx);
        end
        hit = 1'b1;
        step(2);
        frame();
        hit = 1'b0;
        step(2);
        tests_run++;
        if (rv_cnt !== 1 || cap_hit !== 1'b1 || cap_cheat !== 1'b0 || cap_tgt !== 2'd1) begin
            tests_failed++;
            $display("FAIL hit_target1_result: pulses=%0d hit=%b cheat=%b tgt=%0d, required 1 1 0 1",
                     rv_cnt, cap_hit, cap_cheat, cap_tgt);
        end
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL hit_target1_idle: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_no_hit();
        clear_counts();
        pull();
        repeat (4) frame();
        tests_run++;
        if (rv_cnt !== 1 || cap_hit !== 1'b0 || cap_cheat !== 1'b0 || cap_tgt !== 2'd0) begin
            tests_failed++;
            $display("FAIL no_hit_result: pulses=%0d hit=%b cheat=%b tgt=%0d, required 1 0 0 0",
                     rv_cnt, cap_hit, cap_cheat, cap_tgt);
        end
        tests_run++;
        if (blank_cnt !== FRAME_CYC || draw_cnt !== 2 * FRAME_CYC) begin
            tests_failed++;
            $display("FAIL overlay_duration: blank_cycles=%0d draw_cycles=%0d, required %0d %0d",
                     blank_cnt, draw_cnt, FRAME_CYC, 2 * FRAME_CYC);
        end
    endtask

    task automatic test_cheat();
        clear_counts();
        pull();
        frame();
        hit = 1'b1;
        step(1);
        repeat (3) frame();
        hit = 1'b0;
        step(1);
        tests_run++;
        if (rv_cnt !== 1 || cap_hit !== 1'b0 || cap_cheat !== 1'b1 || cap_tgt !== 2'd0) begin
            tests_failed++;
            $display("FAIL cheat_result: pulses=%0d hit=%b cheat=%b tgt=%0d, required 1 0 1 0",
                     rv_cnt, cap_hit, cap_cheat, cap_tgt);
        end
    endtask

    // Hit rise on the very cycle frame_start ends target 0.
    task automatic test_coincident_hit();
        clear_counts();
        pull();
        frame();
        frame();
        hit = 1'b1;
        frame();
        tests_run++;
        if (target_idx !== 2'd1) begin
            tests_failed++;
            $display("FAIL coincident_advance: idx=%0d, required 1", target_idx);
        end
        frame();
        hit = 1'b0;
        step(1);
        tests_run++;
        if (rv_cnt !== 1 || cap_hit !== 1'b1 || cap_cheat !== 1'b0 || cap_tgt !== 2'd0) begin
            tests_failed++;
            $display("FAIL coincident_result: pulses=%0d hit=%b cheat=%b tgt=%0d, required 1 1 0 0",
                     rv_cnt, cap_hit, cap_cheat, cap_tgt);
        end
    endtask

    task automatic test_back_to_back();
        clear_counts();
        shot = 1'b1;
        step(2);
        shot = 1'b0;
        step(1);
        shot = 1'b1;
        step(1);
        repeat (4) frame();
        step(10);
        tests_run++;
        if (rv_cnt !== 1 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL held_shot_hold: pulses=%0d busy=%b, required 1 1", rv_cnt, busy);
        end
        shot = 1'b0;
        step(1);
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL release_to_idle: busy=%b, required 0", busy);
        end
        frame();
        frame();
        tests_run++;
        if (busy !== 1'b0 || rv_cnt !== 1 || blank_cnt !== FRAME_CYC) begin
            tests_failed++;
            $display("FAIL no_queued_shot: busy=%b pulses=%0d blank_cycles=%0d, required 0 1 %0d",
                     busy, rv_cnt, blank_cnt, FRAME_CYC);
        end
    endtask

    task automatic test_async_reset();
        clear_counts();
        pull();
        frame();
        frame();
        step(2);
        #2 rst = 1'b0;
        #1;
        tests_run++;
        if ({blank_screen, draw_target, target_idx, busy, result_valid,
             result_hit, result_cheat, result_target} !== 10'd0) begin
            tests_failed++;
            $display("FAIL async_clear: draw=%b busy=%b idx=%0d rv=%b, required all 0",
                     draw_target, busy, target_idx, result_valid);
        end
        frame();
        frame();
        tests_run++;
        if (rv_cnt !== 0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_no_result: pulses=%0d busy=%b, required 0 0", rv_cnt, busy);
        end
        rst = 1'b1;
        step(2);
        clear_counts();
        pull();
        frame();
        frame();
        hit = 1'b1;
        step(1);
        frame();
        frame();
        hit = 1'b0;
        step(1);
        tests_run++;
        if (rv_cnt !== 1 || cap_hit !== 1'b1 || cap_cheat !== 1'b0 || cap_tgt !== 2'd0) begin
            tests_failed++;
            $display("FAIL post_reset_result: pulses=%0d hit=%b cheat=%b tgt=%0d, required 1 1 0 0",
                     rv_cnt, cap_hit, cap_cheat, cap_tgt);
        end
    endtask

    task automatic test_result_quiet();
        tests_run++;
        if (stray_cnt !== 0) begin
            tests_failed++;
            $display("FAIL result_fields_quiet: stray_cycles=%0d, required 0", stray_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_hit_target1();
        test_no_hit();
        test_cheat();
        test_coincident_hit();
        test_back_to_back();
        test_async_reset();
        test_result_quiet();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
